fft_twiddle_sequencer: RTL and testbench

Sequences twiddle-factor fetches from the twiddle ROM for a radix-2 DIT FFT of run-time length N = 2^L. For every stage and butterfly it computes the twiddle exponent, issues the ROM address, captures the 1-cycle-latency ROM data, and delivers it with stage, butterfly index and last flags. Delivery uses a valid/ready stream to the butterfly datapath. It sits between the FFT control FSM and the twiddle ROM and is the ROM's only master.

---
 rtl/fft_twiddle_sequencer_if.sv | 41 ++++
 rtl/fft_twiddle_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_fft_twiddle_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_twiddle_sequencer_if.sv
// Bus bundle for the twiddle sequencer: the twiddle ROM read port and the
// twiddle delivery stream towards the butterfly datapath.
//
// Handshake semantics:
//   - ROM port: rom_addr_valid_o is a read strobe that the ROM cannot stall.
//     rom_data_valid_i/rom_data_i answer it exactly one cycle later.
//   - Twiddle stream: an entry transfers on a rising clock edge where
//     tw_valid_o and tw_ready_i are both high. Once tw_valid_o is high, the
//     head entry (tw_data_o, tw_stage_o, tw_index_o, tw_last_o) holds steady
//     until it transfers or the run is aborted. tw_valid_o never depends on
//     tw_ready_i.
interface fft_twiddle_sequencer_if #(
    parameter int MAX_FFT_LENGTH_LOG2 = 12
);
    logic [15:0]                    rom_addr_o;
    logic                           rom_addr_valid_o;
    logic [31:0]                    rom_data_i;
    logic                           rom_data_valid_i;
    logic [31:0]                    tw_data_o;
    logic [3:0]                     tw_stage_o;
    logic [MAX_FFT_LENGTH_LOG2-2:0] tw_index_o;
    logic                           tw_last_o;
    logic                           tw_valid_o;
    logic                           tw_ready_i;

    // Sequencer side.
    modport master (
        output rom_addr_o, rom_addr_valid_o,
        input  rom_data_i, rom_data_valid_i,
        output tw_data_o, tw_stage_o, tw_index_o, tw_last_o, tw_valid_o,
        input  tw_ready_i
    );

    // ROM plus butterfly datapath side.
    modport slave (
        input  rom_addr_o, rom_addr_valid_o,
        output rom_data_i, rom_data_valid_i,
        input  tw_data_o, tw_stage_o, tw_index_o, tw_last_o, tw_valid_o,
        output tw_ready_i
    );
endinterface

// File: rtl/fft_twiddle_sequencer.sv
// Twiddle-factor sequencer for a radix-2 DIT FFT of run-time length 2^L.
// Walks stages and butterflies, issues one ROM read per cycle while the
// output buffer has room, and streams {twiddle, stage, index, last} out of
// a small show-ahead FIFO.
module fft_twiddle_sequencer #(
    parameter int MAX_FFT_LENGTH_LOG2 = 12,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [3:0] fft_len_log2_i,
    input  logic       abort_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    output logic [1:0] dbg_state_o,
    fft_twiddle_sequencer_if.master tw_if
);
    localparam int MAX = MAX_FFT_LENGTH_LOG2;
    localparam int IW  = MAX - 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int EW  = 32 + 4 + IW + 1;
    localparam logic [MAX-1:0] ONE     = 1;
    localparam logic [CW:0]    DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    stage_q, stage_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          inflight_q, inflight_d;
    logic [3:0]    sb_stage_q, sb_stage_d;
    logic [IW-1:0] sb_idx_q, sb_idx_d;
    logic          sb_last_q, sb_last_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];

    logic           len_legal;
    logic [MAX-1:0] idx_lim;
    logic           last_issue;
    logic [MAX-1:0] k_scaled;
    logic [CW:0]    occupancy;
    logic           credit;
    logic           issue;
    logic           push;
    logic           pop;
    logic [EW-1:0]  head;

    // Datapath terms: legality, end-of-run detection, exponent and credit.
    // Scaling by 2^(MAX-L) folds into the shift: K = (j mod 2^s) << (MAX-1-s).
    always_comb begin
        len_legal  = (fft_len_log2_i != 4'd0) && (fft_len_log2_i <= 4'(MAX));
        idx_lim    = (ONE << (len_q - 4'd1)) - ONE;
        last_issue = (stage_q == (len_q - 4'd1)) && (idx_q == idx_lim[IW-1:0]);
        k_scaled   = ({1'b0, idx_q} & ((ONE << stage_q) - ONE)) << (4'(MAX - 1) - stage_q);
        occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        credit     = occupancy < DEPTH_C;
        issue      = (state_q == ISSUE) && credit;
        push       = tw_if.rom_data_valid_i && inflight_q;
        pop        = (count_q != '0) && tw_if.tw_ready_i;
        head       = mem_q[rd_ptr_q];
    end

    // Next-state logic: FSM, butterfly counters, in-flight tracking, FIFO pointers.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        stage_d    = stage_q;
        idx_d      = idx_q;
        inflight_d = issue || (inflight_q && !tw_if.rom_data_valid_i);
        sb_stage_d = sb_stage_q;
        sb_idx_d   = sb_idx_q;
        sb_last_d  = sb_last_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);

        if (issue) begin
            sb_stage_d = stage_q;
            sb_idx_d   = idx_q;
            sb_last_d  = last_issue;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_legal) begin
                        state_d = ISSUE;
                        len_d   = fft_len_log2_i;
                        stage_d = 4'd0;
                        idx_d   = '0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    if (last_issue) begin
                        state_d = DRAIN;
                    end else if (idx_q == idx_lim[IW-1:0]) begin
                        stage_d = stage_q + 4'd1;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DRAIN: begin
                // Finish when the last entry leaves and no ROM read is pending.
                if ((count_d == '0) && !inflight_d) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including a start in the same cycle.
        if (abort_i) begin
            state_d    = IDLE;
            stage_d    = 4'd0;
            idx_d      = '0;
            inflight_d = 1'b0;
            done_d     = 1'b0;
            error_d    = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end
    end

    // Control and pointer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            len_q      <= 4'd0;
            stage_q    <= 4'd0;
            idx_q      <= '0;
            inflight_q <= 1'b0;
            sb_stage_q <= 4'd0;
            sb_idx_q   <= '0;
            sb_last_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            stage_q    <= stage_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
            sb_stage_q <= sb_stage_d;
            sb_idx_q   <= sb_idx_d;
            sb_last_q  <= sb_last_d;
            done_q     <= done_d;
            error_q    <= error_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage: ROM word joined with the sideband registered at strobe time.
    always_ff @(posedge clk_i) begin
        if (push && !abort_i && !reset_i) begin
            mem_q[wr_ptr_q] <= {tw_if.rom_data_i, sb_stage_q, sb_idx_q, sb_last_q};
        end
    end

    // Outputs; head fields are masked while empty so stale storage never shows.
    always_comb begin
        busy_o                 = (state_q != IDLE);
        done_o                 = done_q;
        error_o                = error_q;
        dbg_state_o            = state_q;
        tw_if.rom_addr_valid_o = issue;
        tw_if.rom_addr_o       = issue ? {{(16-MAX){1'b0}}, k_scaled[MAX-3:0], k_scaled[MAX-1:MAX-2]}
                                       : 16'h0000;
        tw_if.tw_valid_o       = (count_q != '0);
        tw_if.tw_data_o        = tw_if.tw_valid_o ? head[EW-1 -: 32] : 32'h0;
        tw_if.tw_stage_o       = tw_if.tw_valid_o ? head[IW+4:IW+1] : 4'd0;
        tw_if.tw_index_o       = tw_if.tw_valid_o ? head[IW:1] : '0;
        tw_if.tw_last_o        = tw_if.tw_valid_o && head[0];
    end
endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed testbench for fft_twiddle_sequencer (MAX = 12, FIFO_DEPTH = 4).
// A behavioural ROM answers each strobe one cycle later with a word derived
// from the address; expected addresses are hand-computed tables or the
// exponent formula k = (j mod 2^s) << (L-1-s), scaled by 2^(MAX-L).
module tb_fft_twiddle_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] len;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;

    logic [15:0] strobe_addr_q[$];

    fft_twiddle_sequencer_if #(.MAX_FFT_LENGTH_LOG2(12)) bus ();

    fft_twiddle_sequencer #(
        .MAX_FFT_LENGTH_LOG2(12),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .start_i(start),
        .fft_len_log2_i(len),
        .abort_i(abort),
        .busy_o(busy),
        .done_o(done),
        .error_o(error),
        .dbg_state_o(dbg_state),
        .tw_if(bus)
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(logic [15:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    function automatic logic [15:0] model_addr(int s, int j, int l);
        int k;
        logic [11:0] kk;
        k  = (j % (1 << s)) << (l - 1 - s);
        k  = k << (12 - l);
        kk = 12'(k);
        return {4'h0, kk[9:0], kk[11:10]};
    endfunction

    function automatic logic [15:0] l3_addr(int n);
        case (n)
            5:       return 16'h0001;
            7:       return 16'h0001;
            9:       return 16'h0800;
            10:      return 16'h0001;
            11:      return 16'h0801;
            default: return 16'h0000;
        endcase
    endfunction

    // Behavioural twiddle ROM: one-cycle read latency.
    always_ff @(posedge clk) begin
        bus.rom_data_valid_i <= bus.rom_addr_valid_o;
        bus.rom_data_i       <= rom_word(bus.rom_addr_o);
    end

    // Strobe monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (bus.rom_addr_valid_o === 1'b1) strobe_addr_q.push_back(bus.rom_addr_o);
    end

    // Advance to just after the next falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        int base;
        reset = 1'b1; start = 1'b0; abort = 1'b0; len = 4'd0; bus.tw_ready_i = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, error, bus.rom_addr_valid_o, bus.tw_valid_o, bus.tw_last_o, dbg_state} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b done=%b err=%b strobe=%b valid=%b last=%b state=%0d, want all 0",
                     busy, done, error, bus.rom_addr_valid_o, bus.tw_valid_o, bus.tw_last_o, dbg_state);
        end
        checks++;
        if ({bus.rom_addr_o, bus.tw_data_o, bus.tw_stage_o, bus.tw_index_o} !== 63'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h data=%h s=%0d j=%0d, want 0",
                     bus.rom_addr_o, bus.tw_data_o, bus.tw_stage_o, bus.tw_index_o);
        end
        // Reset in the middle of an L = 5 run.
        start = 1'b1; len = 4'd5; tick(); start = 1'b0;
        repeat (6) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_midrun_busy: got %b, want 1", busy);
        end
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, error, bus.rom_addr_valid_o, bus.tw_valid_o, bus.tw_last_o, dbg_state} !== 8'h00) begin
            errors++;
            $display("FAIL reset_midrun_ctrl: got busy=%b done=%b err=%b strobe=%b valid=%b last=%b state=%0d, want all 0",
                     busy, done, error, bus.rom_addr_valid_o, bus.tw_valid_o, bus.tw_last_o, dbg_state);
        end
        checks++;
        if ({bus.rom_addr_o, bus.tw_data_o, bus.tw_stage_o, bus.tw_index_o} !== 63'h0) begin
            errors++;
            $display("FAIL reset_midrun_bus: got addr=%h data=%h s=%0d j=%0d, want 0",
                     bus.rom_addr_o, bus.tw_data_o, bus.tw_stage_o, bus.tw_index_o);
        end
        base = strobe_addr_q.size();
        repeat (5) tick();
        checks++;
        if (strobe_addr_q.size() != base || bus.tw_valid_o !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet: got %0d strobes valid=%b busy=%b, want 0 strobes valid=0 busy=0",
                     strobe_addr_q.size() - base, bus.tw_valid_o, busy);
        end
    endtask

    task automatic test_l3_order();
        int base, n, cyc, first_valid;
        bit early_done;
        base = strobe_addr_q.size();
        bus.tw_ready_i = 1'b1; len = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; cyc = 1; first_valid = -1; early_done = 1'b0;
        while (n < 12 && cyc < 60) begin
            if (done === 1'b1) early_done = 1'b1;
            if (bus.tw_valid_o === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                checks++;
                if ({bus.tw_stage_o, bus.tw_index_o, bus.tw_last_o, bus.tw_data_o} !==
                    {4'(n / 4), 11'(n % 4), (n == 11), rom_word(l3_addr(n))}) begin
                    errors++;
                    $display("FAIL l3_twiddle[%0d]: got s=%0d j=%0d last=%b data=%h, want s=%0d j=%0d last=%b data=%h",
                             n, bus.tw_stage_o, bus.tw_index_o, bus.tw_last_o, bus.tw_data_o,
                             n / 4, n % 4, (n == 11), rom_word(l3_addr(n)));
                end
                n++;
            end
            tick(); cyc++;
        end
        checks++;
        if (n != 12) begin
            errors++; $display("FAIL l3_count: got %0d twiddles, want 12", n);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || early_done) begin
            errors++;
            $display("FAIL l3_done: got done=%b busy=%b early=%b, want done=1 busy=0 early=0", done, busy, early_done);
        end
        checks++;
        if (first_valid != 3) begin
            errors++; $display("FAIL l3_latency: got first valid at cycle %0d, want 3", first_valid);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL l3_done_pulse: got done=%b a cycle later, want 0", done);
        end
        checks++;
        if (strobe_addr_q.size() - base != 12) begin
            errors++; $display("FAIL l3_strobes: got %0d, want 12", strobe_addr_q.size() - base);
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (strobe_addr_q[base + i] !== l3_addr(i)) begin
                    errors++;
                    $display("FAIL l3_addr[%0d]: got %h, want %h", i, strobe_addr_q[base + i], l3_addr(i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int base, n, cyc, es, ej;
        logic [31:0] ed;
        base = strobe_addr_q.size();
        bus.tw_ready_i = 1'b0; len = 4'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        checks++;
        if (strobe_addr_q.size() - base != 4 || bus.rom_addr_valid_o !== 1'b0 || bus.tw_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: got %0d strobes strobe_now=%b valid=%b, want 4 strobes strobe_now=0 valid=1",
                     strobe_addr_q.size() - base, bus.rom_addr_valid_o, bus.tw_valid_o);
        end
        bus.tw_ready_i = 1'b1;
        n = 0; cyc = 0;
        while (n < 32 && cyc < 300) begin
            if (bus.tw_valid_o === 1'b1) begin
                es = n / 8; ej = n % 8;
                ed = rom_word(model_addr(es, ej, 4));
                checks++;
                if ({bus.tw_stage_o, bus.tw_index_o, bus.tw_last_o, bus.tw_data_o} !==
                    {4'(es), 11'(ej), (n == 31), ed}) begin
                    errors++;
                    $display("FAIL bp_twiddle[%0d]: got s=%0d j=%0d last=%b data=%h, want s=%0d j=%0d last=%b data=%h",
                             n, bus.tw_stage_o, bus.tw_index_o, bus.tw_last_o, bus.tw_data_o,
                             es, ej, (n == 31), ed);
                end
                n++;
            end
            tick(); cyc++;
        end
        checks++;
        if (n != 32 || strobe_addr_q.size() - base != 32) begin
            errors++;
            $display("FAIL bp_count: got %0d twiddles %0d strobes, want 32 and 32", n, strobe_addr_q.size() - base);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_done: got done=%b busy=%b, want 1 0", done, busy);
        end
        tick();
    endtask

    task automatic test_illegal_len();
        int base;
        logic [3:0] bad [2];
        bad[0] = 4'd0; bad[1] = 4'd13;
        base = strobe_addr_q.size();
        for (int i = 0; i < 2; i++) begin
            len = bad[i]; start = 1'b1;
            tick();
            start = 1'b0;
            checks++;
            if (error !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL illegal_err[L=%0d]: got error=%b busy=%b, want 1 0", bad[i], error, busy);
            end
            tick();
            checks++;
            if (error !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL illegal_pulse[L=%0d]: got error=%b busy=%b, want 0 0", bad[i], error, busy);
            end
        end
        checks++;
        if (strobe_addr_q.size() != base) begin
            errors++; $display("FAIL illegal_strobes: got %0d, want 0", strobe_addr_q.size() - base);
        end
    endtask

    task automatic test_abort();
        int base, cyc, n;
        bit seen_valid, seen_done;
        logic [15:0] l2 [4];
        l2[0] = 16'h0000; l2[1] = 16'h0000; l2[2] = 16'h0000; l2[3] = 16'h0001;
        base = strobe_addr_q.size();
        bus.tw_ready_i = 1'b1; len = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (strobe_addr_q.size() - base < 5 && cyc < 20) begin
            tick(); cyc++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.tw_valid_o !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b valid=%b state=%0d, want 0 0 0", busy, bus.tw_valid_o, dbg_state);
        end
        seen_valid = 1'b0; seen_done = 1'b0;
        repeat (4) begin
            if (bus.tw_valid_o === 1'b1) seen_valid = 1'b1;
            if (done === 1'b1) seen_done = 1'b1;
            tick();
        end
        checks++;
        if (seen_valid || seen_done || strobe_addr_q.size() - base != 5) begin
            errors++;
            $display("FAIL abort_quiet: got valid=%b done=%b strobes=%0d, want 0 0 5",
                     seen_valid, seen_done, strobe_addr_q.size() - base);
        end
        // A fresh L = 2 run after the abort.
        len = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 30) begin
            if (bus.tw_valid_o === 1'b1) begin
                checks++;
                if ({bus.tw_stage_o, bus.tw_index_o, bus.tw_last_o, bus.tw_data_o} !==
                    {4'(n / 2), 11'(n % 2), (n == 3), rom_word(l2[n])}) begin
                    errors++;
                    $display("FAIL abort_rerun[%0d]: got s=%0d j=%0d last=%b data=%h, want s=%0d j=%0d last=%b data=%h",
                             n, bus.tw_stage_o, bus.tw_index_o, bus.tw_last_o, bus.tw_data_o,
                             n / 2, n % 2, (n == 3), rom_word(l2[n]));
                end
                n++;
            end
            tick(); cyc++;
        end
        checks++;
        if (n != 4 || done !== 1'b1) begin
            errors++; $display("FAIL abort_rerun_done: got %0d twiddles done=%b, want 4 and 1", n, done);
        end
        tick();
    endtask

    task automatic test_l1_ignore_start();
        int base;
        base = strobe_addr_q.size();
        bus.tw_ready_i = 1'b1; len = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.rom_addr_valid_o !== 1'b1 || bus.rom_addr_o !== 16'h0000) begin
            errors++;
            $display("FAIL l1_issue: got busy=%b strobe=%b addr=%h, want 1 1 0000", busy, bus.rom_addr_valid_o, bus.rom_addr_o);
        end
        tick();
        len = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({bus.tw_valid_o, bus.tw_stage_o, bus.tw_index_o, bus.tw_last_o, bus.tw_data_o} !==
            {1'b1, 4'd0, 11'd0, 1'b1, rom_word(16'h0000)}) begin
            errors++;
            $display("FAIL l1_twiddle: got valid=%b s=%0d j=%0d last=%b data=%h, want 1 0 0 1 %h",
                     bus.tw_valid_o, bus.tw_stage_o, bus.tw_index_o, bus.tw_last_o, bus.tw_data_o, rom_word(16'h0000));
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL l1_done: got done=%b busy=%b, want 1 0", done, busy);
        end
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || strobe_addr_q.size() - base != 1) begin
            errors++;
            $display("FAIL l1_start_ignored: got busy=%b strobes=%0d, want 0 and 1", busy, strobe_addr_q.size() - base);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, n, es, ej;
        logic [31:0] ed;
        bus.tw_ready_i = 1'b1; len = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            tick(); cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL b2b_first_done: got done=%b, want 1", done);
        end
        tick();
        len = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: got busy=%b, want 1", busy);
        end
        n = 0; cyc = 0;
        while (n < 4 && cyc < 30) begin
            if (bus.tw_valid_o === 1'b1) begin
                es = n / 2; ej = n % 2;
                ed = rom_word(model_addr(es, ej, 2));
                checks++;
                if ({bus.tw_stage_o, bus.tw_index_o, bus.tw_last_o, bus.tw_data_o} !== {4'(es), 11'(ej), (n == 3), ed}) begin
                    errors++;
                    $display("FAIL b2b_twiddle[%0d]: got s=%0d j=%0d last=%b data=%h, want s=%0d j=%0d last=%b data=%h",
                             n, bus.tw_stage_o, bus.tw_index_o, bus.tw_last_o, bus.tw_data_o, es, ej, (n == 3), ed);
                end
                n++;
            end
            tick(); cyc++;
        end
        checks++;
        if (n != 4 || done !== 1'b1) begin
            errors++; $display("FAIL b2b_second_done: got %0d twiddles done=%b, want 4 and 1", n, done);
        end
    endtask

    initial begin
        test_reset();
        test_l3_order();
        test_backpressure();
        test_illegal_len();
        test_abort();
        test_l1_ignore_start();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop if a wait ever escapes its cycle budget.
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
